// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, JAL opcode,
// fetch FSM encodings, default cache depth and the JAL immediate decoder.
package inst_fetch_pkg;

  localparam int AddrBus          = 32;
  localparam int InstBus          = 32;
  localparam int ICACHE_LINES_DEF = 64;

  localparam logic [6:0] OPC_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    MISS      = 2'd1,
    MISS_DROP = 2'd2
  } fetch_state_e;

  // J-type immediate, sign-extended to 32 bits.
  function automatic logic [31:0] jal_offset(input logic [InstBus-1:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetch_icache_dm.sv
// Direct-mapped instruction cache, one 32-bit instruction per line.
// Combinational lookup port and a single synchronous fill port.
module icache_dm
  import inst_fetch_pkg::*;
#(
  parameter int LINES  = ICACHE_LINES_DEF,
  parameter int ADDR_W = AddrBus
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:2]    rd_addr,
  output logic                 rd_hit,
  output logic [InstBus-1:0]   rd_inst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:2]    wr_addr,
  input  logic [InstBus-1:0]   wr_inst
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [TAG_W-1:0]   tag_r  [LINES];
  logic [InstBus-1:0] data_r [LINES];
  logic [LINES-1:0]   valid_r;

  logic [IDX_W-1:0] rd_idx_s;
  logic [TAG_W-1:0] rd_tag_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [TAG_W-1:0] wr_tag_s;

  assign rd_idx_s = rd_addr[IDX_W+1:2];
  assign rd_tag_s = rd_addr[ADDR_W-1:IDX_W+2];
  assign wr_idx_s = wr_addr[IDX_W+1:2];
  assign wr_tag_s = wr_addr[ADDR_W-1:IDX_W+2];

  // Lookup: hit needs a valid line with a matching tag.
  always_comb begin
    rd_hit  = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s);
    rd_inst = data_r[rd_idx_s];
  end

  // Valid bits are the only cache state cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_idx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and data arrays, written on a fill.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_idx_s]  <= wr_tag_s;
      data_r[wr_idx_s] <= wr_inst;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, icache lookup, miss handling and decoder slot.
// Optional static JAL redirect enabled by defining JAL_PREDICT_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ICACHE_LINES = ICACHE_LINES_DEF,
  parameter int ADDR_W       = AddrBus
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  output logic                oMC_en,
  output logic [ADDR_W-1:0]   oMC_addr,
  input  logic                iMC_done,
  input  logic [InstBus-1:0]  iMC_inst,
  output logic                oDEC_valid,
  output logic [InstBus-1:0]  oDEC_inst,
  output logic [ADDR_W-1:0]   oDEC_pc,
  output logic                oDEC_pred_taken,
  input  logic                iDEC_stall,
  input  logic                iROB_flush,
  input  logic [ADDR_W-1:0]   iROB_pc
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  fetch_state_e        state_r;
  logic [ADDR_W-1:0]   pc_r;
  logic                mc_en_r;
  logic [ADDR_W-1:0]   mc_addr_r;
  logic                dec_valid_r;
  logic [InstBus-1:0]  dec_inst_r;
  logic [ADDR_W-1:0]   dec_pc_r;
  logic                dec_pred_r;

  logic                hit_s;
  logic [InstBus-1:0]  hit_inst_s;
  logic                fill_s;
  logic                slot_free_s;
  logic                consume_s;
  logic [ADDR_W-1:0]   next_pc_s;
  logic                pred_s;

  // The fill lands whenever a request is outstanding and done arrives, flush or not.
  assign fill_s      = rdy && iMC_done && (state_r != FETCH);
  assign slot_free_s = !dec_valid_r || !iDEC_stall;
  assign consume_s   = dec_valid_r && !iDEC_stall;

  icache_dm #(
    .LINES  (ICACHE_LINES),
    .ADDR_W (ADDR_W)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (pc_r[ADDR_W-1:2]),
    .rd_hit  (hit_s),
    .rd_inst (hit_inst_s),
    .wr_en   (fill_s),
    .wr_addr (mc_addr_r[ADDR_W-1:2]),
    .wr_inst (iMC_inst)
  );

`ifdef JAL_PREDICT_EN
  logic signed [31:0] jal_off_s;
  assign jal_off_s = signed'(jal_offset(hit_inst_s));

  // Next PC: JAL target on a JAL hit, sequential otherwise.
  always_comb begin
    if (hit_inst_s[6:0] == OPC_JAL) begin
      pred_s    = 1'b1;
      next_pc_s = pc_r + ADDR_W'(jal_off_s);
    end else begin
      pred_s    = 1'b0;
      next_pc_s = pc_r + PC_STEP;
    end
  end
`else
  // Next PC: always sequential.
  always_comb begin
    pred_s    = 1'b0;
    next_pc_s = pc_r + PC_STEP;
  end
`endif

  // Fetch FSM, PC, memory request and decoder output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= FETCH;
      pc_r        <= '0;
      mc_en_r     <= 1'b0;
      mc_addr_r   <= '0;
      dec_valid_r <= 1'b0;
      dec_inst_r  <= '0;
      dec_pc_r    <= '0;
      dec_pred_r  <= 1'b0;
    end else if (rdy) begin
      if (consume_s) begin
        dec_valid_r <= 1'b0;
      end
      if (iROB_flush) begin
        pc_r        <= iROB_pc;
        dec_valid_r <= 1'b0;
        case (state_r)
          FETCH: state_r <= FETCH;
          MISS, MISS_DROP: begin
            // No abort on the memory side: keep requesting until done.
            if (iMC_done) begin
              mc_en_r <= 1'b0;
              state_r <= FETCH;
            end else begin
              state_r <= MISS_DROP;
            end
          end
          default: begin
            mc_en_r <= 1'b0;
            state_r <= FETCH;
          end
        endcase
      end else begin
        case (state_r)
          FETCH: begin
            if (hit_s) begin
              if (slot_free_s) begin
                dec_valid_r <= 1'b1;
                dec_inst_r  <= hit_inst_s;
                dec_pc_r    <= pc_r;
                dec_pred_r  <= pred_s;
                pc_r        <= next_pc_s;
              end
            end else begin
              mc_en_r   <= 1'b1;
              mc_addr_r <= {pc_r[ADDR_W-1:2], 2'b00};
              state_r   <= MISS;
            end
          end
          MISS, MISS_DROP: begin
            if (iMC_done) begin
              mc_en_r <= 1'b0;
              state_r <= FETCH;
            end
          end
          default: begin
            mc_en_r <= 1'b0;
            state_r <= FETCH;
          end
        endcase
      end
    end
  end

  assign oMC_en          = mc_en_r;
  assign oMC_addr        = mc_addr_r;
  assign oDEC_valid      = dec_valid_r;
  assign oDEC_inst       = dec_inst_r;
  assign oDEC_pc         = dec_pc_r;
  assign oDEC_pred_taken = dec_pred_r;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the RISC-V core. Holds the PC, looks it up in a direct-mapped instruction cache, and on a miss issues a word read to the memory controller's instruction port (`INF`). It then presents one instruction per cycle to the decoder through a valid/stall handshake and redirects on a ROB flush.

## Interface
Parameters:
- ICACHE_LINES, 64, number of lines (one 32-bit instruction each); power of two; index = pc[log2(ICACHE_LINES)+1:2].
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  reset, asynchronous, active-high.
- rdy  in  1  global enable; when low, every register holds.
- oMC_en  out  1  fetch request to memory controller.
- oMC_addr  out  ADDR_W  word-aligned fetch address.
- iMC_done  in  1  one-cycle pulse: iMC_inst valid.
- iMC_inst  in  32  fetched instruction.
- oDEC_valid  out  1  instruction presented to decoder.
- oDEC_inst  out  32  instruction.
- oDEC_pc  out  ADDR_W  its PC.
- oDEC_pred_taken  out  1  fetch redirected on this instruction (JAL prediction).
- iDEC_stall  in  1  decoder cannot accept this cycle.
- iROB_flush  in  1  mispredict/exception redirect.
- iROB_pc  in  ADDR_W  redirect target.

## Operation
- States: FETCH, MISS, MISS_DROP.
- Reset values:
  - pc = 0; state = FETCH.
  - All cache valid bits = 0.
  - oMC_en = 0, oMC_addr = 0.
  - oDEC_valid = 0, oDEC_inst = 0, oDEC_pc = 0, oDEC_pred_taken = 0.
- FETCH:
  - Combinational lookup of pc.
  - Hit and output slot free (oDEC_valid = 0 or iDEC_stall = 0): load oDEC_* with pc/inst, oDEC_valid <= 1, pc <= next_pc.
  - Hit but slot blocked: hold everything.
  - Miss: oMC_en <= 1, oMC_addr <= pc, state <= MISS.
- MISS:
  - Hold oMC_en/oMC_addr stable.
  - On iMC_done: write line (tag, inst, valid), oMC_en <= 0, state <= FETCH. The next cycle hits.
- MISS_DROP: identical to MISS, but entered after a flush. The fill still writes the cache, then the FSM returns to FETCH at the already-redirected pc.
- Output slot:
  - Consumed at any edge with oDEC_valid = 1 and iDEC_stall = 0.
  - If not refilled at that edge, oDEC_valid <= 0.
  - While stalled, oDEC_inst/oDEC_pc/oDEC_pred_taken are held unchanged.
- Flush (highest priority below rst and rdy):
  - pc <= iROB_pc; oDEC_valid <= 0.
  - State FETCH stays FETCH; MISS or MISS_DROP goes to MISS_DROP.
  - If iMC_done coincides with flush: the cache is written and state goes to FETCH.
  - The memory controller has no abort, so oMC_en is never dropped before iMC_done.
- next_pc = pc + 4, 32-bit wrap-around (0xFFFFFFFC -> 0).

## Timing
- Hit: pc visible on oDEC_* one edge after lookup; throughput of one instruction per cycle.
- Miss:
  - oMC_en rises at the edge after the miss is detected.
  - oMC_en falls at the edge sampling iMC_done, so the controller returns to idle without seeing a repeat request.
  - The instruction is presented at done + 2 edges (fill, then hit).
- Flush to first new-PC output: at least 2 edges on a hit. On a flush during a miss: the remaining miss cycles + fill + hit.
- rdy = 0 freezes the FSM, cache writes and outputs. iMC_done is ignored while rdy = 0; the memory controller also freezes under rdy = 0.

## Configuration
- JAL_PREDICT_EN defined:
  - A hit instruction with opcode 7'b1101111 sets next_pc = pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - oDEC_pred_taken is loaded with 1 for that instruction.
- JAL_PREDICT_EN undefined: next_pc is always pc + 4 and oDEC_pred_taken is constant 0.

## Structure
- Shared config header/package holds:
  - AddrBus, InstBus widths.
  - OPC_JAL.
  - Fetch state encodings.
  - ICACHE_LINES default.
- Sub-module icache_dm:
  - Tag/data/valid arrays with asynchronous reset of the valid bits.
  - Combinational hit/inst read port, single synchronous write port.
- FSM, pc and output slot live in inst_fetch.

## Test plan
- Cold start: memory[0] = 0x00000013, rst released -> oMC_en = 1, oMC_addr = 0x0 next edge; iMC_done pulse -> 2 edges later oDEC_valid = 1, oDEC_inst = 0x00000013, oDEC_pc = 0x0.
- Warm loop: 0x0–0xC cached, iDEC_stall = 0 -> oDEC_pc = 0x0, 0x4, 0x8, 0xC on four consecutive cycles with oDEC_valid = 1, oMC_en = 0.
- Stall: iDEC_stall = 1 for 3 cycles while presenting pc 0x4 -> oDEC_* unchanged, no new fetch; release -> 0x8 next edge.
- Flush in miss: iROB_flush with iROB_pc = 0x100 during the miss on 0x40 -> oMC_addr stays 0x40 until done; no output with pc 0x40; next valid output has pc 0x100.
- Conflict: ICACHE_LINES = 64, fetch 0x0 then 0x100 (same index 0, different tag) -> second fetch misses; refetching 0x0 misses again.
- JAL at 0x8 = 0x0100006F -> with JAL_PREDICT_EN the next oDEC_pc is 0x18 and oDEC_pred_taken = 1 for 0x8; without it the next is 0xC and the flag is 0.
